cabac_lps_pipe: RTL and testbench

CABAC_LPS_PIPE -- requirements
Module: cabac_lps_pipe

---
 rtl/cabac_lps_pipe.sv | 112 +++++++++++
 tb/tb_cabac_lps_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cabac_lps_pipe.sv
// rtl/cabac_lps_pipe.sv - two-stage CABAC LPS sub-range pipeline with valid/ready handshake
module cabac_lps_pipe #(
  parameter int STATE_W = 8,
  parameter int RANGE_W = 9,
  parameter int LPS_W   = 8,
  parameter int DUAL    = 0,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] s0,
  input  logic [STATE_W-1:0] s1,
  input  logic [RANGE_W-1:0] range,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LPS_W-1:0]   lps,
  output logic [RANGE_W-1:0] rmps,
  output logic               mps,
  output logic [TAG_W-1:0]   out_tag,
  output logic               err
);

  localparam int QS_W   = 5;
  localparam int RS_W   = 4;
  localparam int PROD_W = QS_W + RS_W;
  localparam int LPSF_W = PROD_W + 1;
  localparam int DIFF_W = (RANGE_W > LPSF_W) ? RANGE_W : LPSF_W;

  // Stage 1 front end: effective state, fold and scaling
  logic [STATE_W:0]   st_sum;
  logic [STATE_W-1:0] st;
  logic               mps_in;
  logic [STATE_W-2:0] q;
  logic [QS_W-1:0]    qs_in;
  logic [RS_W-1:0]    rs_in;

  assign st_sum = {1'b0, s0} + {1'b0, s1};
  assign st     = (DUAL != 0) ? STATE_W'(st_sum >> 1) : s0;
  assign mps_in = st[STATE_W-1];
  assign q      = mps_in ? ~st[STATE_W-2:0] : st[STATE_W-2:0];
  assign qs_in  = QS_W'(q >> (STATE_W - 6));
  assign rs_in  = RS_W'(range >> (RANGE_W - 4));

  // Stage 1 registers; the state travels as its mps bit plus its folded/scaled form
  logic               s1_valid;
  logic               s1_mps;
  logic [RANGE_W-1:0] s1_range;
  logic [QS_W-1:0]    s1_qs;
  logic [RS_W-1:0]    s1_rs;
  logic [TAG_W-1:0]   s1_tag;

  // Stage 2 arithmetic on stage 1 contents
  logic [PROD_W-1:0] prod;
  logic [LPSF_W-1:0] lps_full;
  logic [DIFF_W-1:0] diff;

  assign prod     = PROD_W'(s1_qs) * PROD_W'(s1_rs);
  assign lps_full = LPSF_W'(prod >> 1) + LPSF_W'(4);
  assign diff     = DIFF_W'(s1_range) - DIFF_W'(lps_full);

  logic s1_adv;
  logic in_fire;

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s1_adv);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mps    <= 1'b0;
      s1_range  <= '0;
      s1_qs     <= '0;
      s1_rs     <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      lps       <= '0;
      rmps      <= '0;
      mps       <= 1'b0;
      out_tag   <= '0;
      err       <= 1'b0;
    end else begin
      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          lps     <= LPS_W'(lps_full);
          rmps    <= RANGE_W'(diff);
          mps     <= s1_mps;
          out_tag <= s1_tag;
        end
      end
      if (!s1_valid || s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mps   <= mps_in;
          s1_range <= range;
          s1_qs    <= qs_in;
          s1_rs    <= rs_in;
          s1_tag   <= in_tag;
        end
      end
      // A non-normalised range still produces a result but is flagged until reset
      if (in_fire && !range[RANGE_W-1]) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cabac_lps_pipe.sv
// tb/tb_cabac_lps_pipe.sv - directed self-checking bench for cabac_lps_pipe
module tb_cabac_lps_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv_a, ir_a, ov_a, ordy_a, mps_a, err_a;
  logic [7:0] s0_a, s1_a, lps_a;
  logic [8:0] rng_a, rmps_a;
  logic [3:0] tag_a, otag_a;

  logic       iv_b, ir_b, ov_b, ordy_b, mps_b, err_b;
  logic [7:0] s0_b, s1_b, lps_b;
  logic [8:0] rng_b, rmps_b;
  logic [3:0] tag_b, otag_b;

  cabac_lps_pipe #(.STATE_W(8), .RANGE_W(9), .LPS_W(8), .DUAL(0), .TAG_W(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .s0(s0_a), .s1(s1_a),
    .range(rng_a), .in_tag(tag_a), .out_valid(ov_a), .out_ready(ordy_a), .lps(lps_a),
    .rmps(rmps_a), .mps(mps_a), .out_tag(otag_a), .err(err_a)
  );

  cabac_lps_pipe #(.STATE_W(8), .RANGE_W(9), .LPS_W(8), .DUAL(1), .TAG_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .s0(s0_b), .s1(s1_b),
    .range(rng_b), .in_tag(tag_b), .out_valid(ov_b), .out_ready(ordy_b), .lps(lps_b),
    .rmps(rmps_b), .mps(mps_b), .out_tag(otag_b), .err(err_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_chk(input int which, input logic [7:0] v0, input logic [7:0] v1,
                          input logic [8:0] rg, input logic [3:0] tg,
                          input int el, input int er, input int em, input string nm);
    int cnt;
    @(negedge clk);
    if (which == 0) begin
      iv_a = 1'b1; s0_a = v0; s1_a = v1; rng_a = rg; tag_a = tg;
    end else begin
      iv_b = 1'b1; s0_b = v0; s1_b = v1; rng_b = rg; tag_b = tg;
    end
    #1;
    chk({nm, "_in_ready"}, (which == 0) ? ir_a : ir_b, 1);
    @(negedge clk);
    iv_a = 1'b0;
    iv_b = 1'b0;
    cnt = 1;
    while ((((which == 0) ? ov_a : ov_b) == 1'b0) && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk({nm, "_latency"}, cnt, 2);
    chk({nm, "_lps"}, (which == 0) ? lps_a : lps_b, el);
    chk({nm, "_rmps"}, (which == 0) ? rmps_a : rmps_b, er);
    chk({nm, "_mps"}, (which == 0) ? mps_a : mps_b, em);
    chk({nm, "_tag"}, (which == 0) ? otag_a : otag_b, tg);
    @(negedge clk);
    chk({nm, "_no_dup"}, (which == 0) ? ov_a : ov_b, 0);
  endtask

  logic [7:0] t_s0   [8] = '{8'h00, 8'h40, 8'hC0, 8'hFF, 8'h7F, 8'h20, 8'h90, 8'h55};
  logic [8:0] t_rng  [8] = '{9'd256, 9'd510, 9'd256, 9'd511, 9'd511, 9'd300, 9'd400, 9'd333};
  int         t_lps  [8] = '{4, 124, 64, 4, 236, 40, 166, 109};
  int         t_rmps [8] = '{252, 386, 192, 507, 275, 260, 234, 224};
  int         t_mps  [8] = '{0, 0, 1, 1, 0, 0, 1, 0};

  initial begin
    int sent;
    int rcv;
    int inflight;
    logic hold;
    logic [7:0] h_lps;
    logic [8:0] h_rmps;
    logic h_mps;
    logic [3:0] h_tag;

    iv_a = 0; s0_a = 0; s1_a = 0; rng_a = 0; tag_a = 0; ordy_a = 1;
    iv_b = 0; s0_b = 0; s1_b = 0; rng_b = 0; tag_b = 0; ordy_b = 1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_lps", lps_a, 0);
    chk("rst_rmps", rmps_a, 0);
    chk("rst_mps", mps_a, 0);
    chk("rst_out_tag", otag_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_in_ready", ir_a, 0);
    chk("rst_in_ready_b", ir_b, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready", ir_a, 1);

    send_chk(0, 8'h00, 8'hA5, 9'd256, 4'h1, 4, 252, 0, "s00_r256");
    send_chk(0, 8'h40, 8'h3C, 9'd510, 4'h2, 124, 386, 0, "s40_r510");
    send_chk(0, 8'hC0, 8'hFF, 9'd256, 4'h3, 64, 192, 1, "sC0_r256");
    send_chk(0, 8'hFF, 8'h00, 9'd511, 4'h4, 4, 507, 1, "sFF_r511");
    send_chk(0, 8'h7F, 8'h11, 9'd511, 4'h5, 236, 275, 0, "s7F_r511");
    send_chk(1, 8'h40, 8'h20, 9'd384, 4'h6, 76, 308, 0, "dual_40_20");
    send_chk(1, 8'hFF, 8'hFF, 9'd511, 4'h7, 4, 507, 1, "dual_FF_FF");
    chk("err_clean", err_a, 0);

    sent = 0;
    rcv  = 0;
    hold = 1'b0;
    h_lps = 0; h_rmps = 0; h_mps = 0; h_tag = 0;
    for (int cyc = 0; cyc < 80 && rcv < 8; cyc++) begin
      @(negedge clk);
      ordy_a = (cyc % 3 == 0);
      if (sent < 8) begin
        iv_a = 1'b1; s0_a = t_s0[sent]; s1_a = 8'h5A; rng_a = t_rng[sent]; tag_a = sent[3:0];
      end else begin
        iv_a = 1'b0;
      end
      #1;
      inflight = sent - rcv;
      chk("stream_in_ready", ir_a, !(inflight == 2 && !ordy_a));
      if (hold) begin
        chk("stall_valid", ov_a, 1);
        chk("stall_lps", lps_a, h_lps);
        chk("stall_rmps", rmps_a, h_rmps);
        chk("stall_mps", mps_a, h_mps);
        chk("stall_tag", otag_a, h_tag);
      end
      if (ov_a && ordy_a && rcv < 8) begin
        chk("stream_lps", lps_a, t_lps[rcv]);
        chk("stream_rmps", rmps_a, t_rmps[rcv]);
        chk("stream_mps", mps_a, t_mps[rcv]);
        chk("stream_tag", otag_a, rcv);
        rcv++;
      end
      hold = ov_a && !ordy_a;
      h_lps = lps_a; h_rmps = rmps_a; h_mps = mps_a; h_tag = otag_a;
      if (iv_a && ir_a) sent++;
    end
    iv_a = 1'b0;
    ordy_a = 1'b1;
    chk("stream_count", rcv, 8);
    @(negedge clk);
    chk("stream_drained", ov_a, 0);

    send_chk(0, 8'h40, 8'h00, 9'd200, 4'h9, 52, 148, 0, "low_range");
    chk("err_set", err_a, 1);
    send_chk(0, 8'h00, 8'h00, 9'd256, 4'hA, 4, 252, 0, "after_err");
    chk("err_sticky", err_a, 1);

    @(negedge clk);
    ordy_a = 1'b0;
    iv_a = 1'b1; s0_a = 8'h40; rng_a = 9'd510; tag_a = 4'hB;
    @(negedge clk);
    tag_a = 4'hC;
    @(negedge clk);
    iv_a = 1'b0;
    #1;
    chk("full_out_valid", ov_a, 1);
    chk("full_in_ready", ir_a, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", ov_a, 0);
    chk("midrst_err", err_a, 0);
    chk("midrst_in_ready", ir_a, 0);
    chk("midrst_lps", lps_a, 0);
    rst = 1'b0;
    ordy_a = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", ir_a, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", ov_a, 0);
    end
    chk("post_rst_err", err_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
